// File: rtl/rom_load_pkg.sv
// Shared types and constants for the ROM download sequencer and its region decoder.
package rom_load_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_HOLD,
        ST_RUN
    } state_t;

    localparam int NUM_REGIONS = 4;

    localparam int ERR_OVERRUN = 0;
    localparam int ERR_RANGE   = 1;

endpackage

// File: rtl/rom_region_dec.sv
// Address to ROM region decoder: one-hot region, region-local address, in-range flag.
// Purely combinational; no backpressure.
module rom_region_dec #(
    parameter int          ADDR_W = 25,
    parameter logic [15:0] END0   = 16'h8000,
    parameter logic [15:0] END1   = 16'hA000,
    parameter logic [15:0] END2   = 16'hC000,
    parameter logic [16:0] END3   = 17'h10000
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [3:0]        region,
    output logic [15:0]       local_addr,
    output logic              in_range
);

    always_comb begin
        region     = '0;
        local_addr = '0;
        in_range   = (addr < ADDR_W'(END3));
        if (addr < ADDR_W'(END0)) begin
            region     = 4'b0001;
            local_addr = addr[15:0];
        end else if (addr < ADDR_W'(END1)) begin
            region     = 4'b0010;
            local_addr = addr[15:0] - END0;
        end else if (addr < ADDR_W'(END2)) begin
            region     = 4'b0100;
            local_addr = addr[15:0] - END1;
        end else if (in_range) begin
            region     = 4'b1000;
            local_addr = addr[15:0] - END2;
        end
    end

endmodule

// File: rtl/rom_load_ctrl.sv
// Sequences the HPS ROM download into four ROM regions and owns the game core reset.
// Write request appears one cycle after ioctl_wr; ioctl_wait holds hps_io until rom_ack.
module rom_load_ctrl
    import rom_load_pkg::*;
#(
    parameter logic [15:0] END0        = 16'h8000,
    parameter logic [15:0] END1        = 16'hA000,
    parameter logic [15:0] END2        = 16'hC000,
    parameter logic [16:0] END3        = 17'h10000,
    parameter int          HOLD_CYCLES = 1024
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic                   soft_reset,
    input  logic                   ioctl_download,
    input  logic                   ioctl_wr,
    input  logic [24:0]            ioctl_addr,
    input  logic [7:0]             ioctl_dout,
    output logic                   ioctl_wait,
    output logic [NUM_REGIONS-1:0] rom_we,
    output logic [15:0]            rom_addr,
    output logic [7:0]             rom_data,
    input  logic                   rom_ack,
    output logic                   core_reset,
    output logic                   load_done,
    output logic [1:0]             err,
    output logic [7:0]             checksum
);

    localparam int                CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t                   state;
    logic [CNT_W-1:0]         hold_cnt;
    logic                     dl_q;
    logic                     dl_rise;
    logic                     got_byte;

    logic [NUM_REGIONS-1:0]   dec_region;
    logic [15:0]              dec_local;
    logic                     dec_in_range;

    rom_region_dec #(
        .ADDR_W (25),
        .END0   (END0),
        .END1   (END1),
        .END2   (END2),
        .END3   (END3)
    ) u_dec (
        .addr       (ioctl_addr),
        .region     (dec_region),
        .local_addr (dec_local),
        .in_range   (dec_in_range)
    );

    assign dl_rise = ioctl_download & ~dl_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            hold_cnt   <= '0;
            dl_q       <= 1'b0;
            got_byte   <= 1'b0;
            rom_we     <= '0;
            rom_addr   <= '0;
            rom_data   <= '0;
            ioctl_wait <= 1'b0;
            core_reset <= 1'b1;
            load_done  <= 1'b0;
            err        <= '0;
            checksum   <= '0;
        end else begin
            dl_q <= ioctl_download;

            // A new download wins over everything, including a write still awaiting ack.
            if (dl_rise) begin
                state      <= ST_LOAD;
                rom_we     <= '0;
                ioctl_wait <= 1'b0;
                core_reset <= 1'b1;
                load_done  <= 1'b0;
                err        <= '0;
                checksum   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state    <= ST_HOLD;
                        hold_cnt <= HOLD_LOAD;
                    end

                    ST_LOAD: begin
                        if (!ioctl_download) begin
                            state    <= ST_HOLD;
                            hold_cnt <= HOLD_LOAD;
                        end else if (ioctl_wr) begin
                            if (dec_in_range) begin
                                rom_we     <= dec_region;
                                rom_addr   <= dec_local;
                                rom_data   <= ioctl_dout;
                                checksum   <= checksum + ioctl_dout;
                                ioctl_wait <= 1'b1;
                                got_byte   <= 1'b1;
                                state      <= ST_WRITE;
                            end else begin
                                err[ERR_RANGE] <= 1'b1;
                            end
                        end
                    end

                    ST_WRITE: begin
                        if (ioctl_wr) begin
                            err[ERR_OVERRUN] <= 1'b1;
                        end
                        // A download that ended mid-write still completes the byte first.
                        if (rom_ack && (rom_we != '0)) begin
                            rom_we     <= '0;
                            ioctl_wait <= 1'b0;
                            if (ioctl_download) begin
                                state <= ST_LOAD;
                            end else begin
                                state    <= ST_HOLD;
                                hold_cnt <= HOLD_LOAD;
                            end
                        end
                    end

                    ST_HOLD: begin
                        core_reset <= 1'b1;
                        if (soft_reset) begin
                            hold_cnt <= HOLD_LOAD;
                        end else if (hold_cnt == '0) begin
                            state      <= ST_RUN;
                            core_reset <= 1'b0;
                            load_done  <= got_byte && (err == 2'b00);
                        end else begin
                            hold_cnt <= hold_cnt - 1'b1;
                        end
                    end

                    ST_RUN: begin
                        core_reset <= 1'b0;
                        if (soft_reset) begin
                            core_reset <= 1'b1;
                            state      <= ST_HOLD;
                            hold_cnt   <= HOLD_LOAD;
                        end
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Randomised scoreboard bench for rom_load_ctrl with a region/checksum reference model.
module tb_rom_load_ctrl;

    localparam int          HOLD = 8;
    localparam logic [24:0] E0   = 25'h08000;
    localparam logic [24:0] E1   = 25'h0A000;
    localparam logic [24:0] E2   = 25'h0C000;
    localparam logic [24:0] E3   = 25'h10000;

    logic        clk_sys        = 1'b0;
    logic        reset_n        = 1'b0;
    logic        soft_reset     = 1'b0;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr       = 1'b0;
    logic [24:0] ioctl_addr     = '0;
    logic [7:0]  ioctl_dout     = '0;
    logic        rom_ack        = 1'b0;
    logic        ioctl_wait;
    logic [3:0]  rom_we;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic        core_reset;
    logic        load_done;
    logic [1:0]  err;
    logic [7:0]  checksum;

    always #5 clk_sys = ~clk_sys;

    rom_load_ctrl #(.HOLD_CYCLES(HOLD)) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .soft_reset     (soft_reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .rom_we         (rom_we),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .rom_ack        (rom_ack),
        .core_reset     (core_reset),
        .load_done      (load_done),
        .err            (err),
        .checksum       (checksum)
    );

    typedef struct packed {
        logic [3:0]  we;
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    int   total = 0;
    int   bad   = 0;
    wr_t  exp_q[$];
    int   exp_sum  = 0;
    logic [1:0] exp_err = 2'b00;
    bit   got_byte = 0;
    int   ack_lat  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
        end
    endtask

    function automatic wr_t model_wr(input logic [24:0] a, input logic [7:0] d);
        wr_t         r;
        int          idx;
        logic [24:0] base;
        if (a < E0)      begin idx = 0; base = 25'd0; end
        else if (a < E1) begin idx = 1; base = E0;    end
        else if (a < E2) begin idx = 2; base = E1;    end
        else             begin idx = 3; base = E2;    end
        r.we   = 4'(1 << idx);
        r.addr = 16'(a - base);
        r.data = d;
        return r;
    endfunction

    // Target side: acks each request after ack_lat cycles.
    initial begin
        int n;
        n = 0;
        forever begin
            @(posedge clk_sys);
            #1;
            if (rom_we != 4'b0000) begin
                rom_ack = (n >= ack_lat);
                n++;
            end else begin
                rom_ack = 1'b0;
                n = 0;
            end
        end
    end

    always @(negedge clk_sys) begin : monitor
        wr_t w;
        if (reset_n && rom_we != 4'b0000 && rom_ack) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: we=%b addr=0x%0h data=0x%0h", rom_we, rom_addr, rom_data);
            end else begin
                w = exp_q.pop_front();
                check("wr_we",   32'(rom_we),   32'(w.we));
                check("wr_addr", 32'(rom_addr), 32'(w.addr));
                check("wr_data", 32'(rom_data), 32'(w.data));
            end
        end
    end

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d, input bit overrun);
        int n;
        n = 0;
        @(negedge clk_sys);
        while (ioctl_wait && n < 50) begin
            @(negedge clk_sys);
            n++;
        end
        if (ioctl_wait) begin
            total++;
            bad++;
            $display("FAIL wait_timeout: ioctl_wait=1 required 0");
        end
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        if (a < E3) begin
            exp_q.push_back(model_wr(a, d));
            exp_sum  = (exp_sum + int'(d)) % 256;
            got_byte = 1;
        end else begin
            exp_err[1] = 1'b1;
        end
        @(posedge clk_sys);
        #1;
        ioctl_wr = 1'b0;
        if (overrun && a < E3) begin
            ioctl_addr = 25'h00123;
            ioctl_dout = 8'hEE;
            ioctl_wr   = 1'b1;
            exp_err[0] = 1'b1;
            @(posedge clk_sys);
            #1;
            ioctl_wr = 1'b0;
        end
    endtask

    // Counts cycles core_reset stays high, starting after the next rising edge.
    task automatic measure_hold(output int n);
        n = 0;
        @(posedge clk_sys);
        forever begin
            @(negedge clk_sys);
            if (!core_reset || n >= 200) break;
            n++;
        end
    endtask

    task automatic start_dl();
        @(negedge clk_sys);
        ioctl_download = 1'b1;
        exp_sum = 0;
        exp_err = 2'b00;
        @(posedge clk_sys);
        @(posedge clk_sys);
        #1;
        check("start_err",      32'(err),        32'd0);
        check("start_checksum", 32'(checksum),   32'd0);
        check("start_core_rst", 32'(core_reset), 32'd1);
    endtask

    task automatic end_dl(input string tag);
        int n;
        int h;
        n = 0;
        @(negedge clk_sys);
        while ((ioctl_wait || rom_we != 4'b0000) && n < 50) begin
            @(negedge clk_sys);
            n++;
        end
        ioctl_download = 1'b0;
        measure_hold(h);
        check({tag, "_hold"},      32'(h),         32'(HOLD));
        check({tag, "_checksum"},  32'(checksum),  32'(exp_sum));
        check({tag, "_err"},       32'(err),       32'(exp_err));
        check({tag, "_load_done"}, 32'(load_done), 32'(got_byte && exp_err == 2'b00));
    endtask

    initial begin
        int h;
        int n;
        bit stable;
        logic [3:0] we0;
        logic [15:0] a0;
        logic [24:0] a;

        // Reset state and power-up hold.
        @(negedge clk_sys);
        check("rst_we",        32'(rom_we),     32'd0);
        check("rst_wait",      32'(ioctl_wait), 32'd0);
        check("rst_addr",      32'(rom_addr),   32'd0);
        check("rst_data",      32'(rom_data),   32'd0);
        check("rst_core_rst",  32'(core_reset), 32'd1);
        check("rst_load_done", 32'(load_done),  32'd0);
        check("rst_err",       32'(err),        32'd0);
        check("rst_checksum",  32'(checksum),   32'd0);
        reset_n = 1'b1;
        measure_hold(h);
        check("pwr_hold",      32'(h),         32'(HOLD));
        check("pwr_load_done", 32'(load_done), 32'd0);

        // One byte into each region, ack always ready.
        ack_lat = 0;
        start_dl();
        wr_byte(25'h00000, 8'h01, 0);
        wr_byte(25'h08000, 8'h02, 0);
        wr_byte(25'h0A001, 8'h03, 0);
        wr_byte(25'h0FFFF, 8'h04, 0);
        end_dl("dl4");
        check("dl4_sum_lit", 32'(checksum), 32'h0A);

        // Soft reset in RUN: hold again, load_done kept.
        @(negedge clk_sys);
        soft_reset = 1'b1;
        @(posedge clk_sys);
        #1;
        soft_reset = 1'b0;
        n = 0;
        forever begin
            @(negedge clk_sys);
            if (!core_reset || n >= 200) break;
            n++;
        end
        check("soft_hold",      32'(n),         32'(HOLD));
        check("soft_load_done", 32'(load_done), 32'd1);

        // Slow ack, then an overrun.
        start_dl();
        ack_lat = 5;
        wr_byte(25'h01234, 8'h55, 0);
        we0 = rom_we;
        a0  = rom_addr;
        stable = 1;
        n = 0;
        @(negedge clk_sys);
        while (ioctl_wait && n < 50) begin
            n++;
            if (rom_we !== we0 || rom_addr !== a0) stable = 0;
            @(negedge clk_sys);
        end
        check("slow_wait_cycles", 32'(n),      32'd6);
        check("slow_we_stable",   32'(stable), 32'd1);
        ack_lat = 2;
        wr_byte(25'h09000, 8'h66, 0);
        wr_byte(25'h00100, 8'h11, 1);
        wr_byte(25'h0C010, 8'h22, 0);
        end_dl("ovr");

        // Restart clears errors; out-of-range byte dropped.
        start_dl();
        ack_lat = 0;
        wr_byte(25'h10000, 8'h77, 0);
        wr_byte(25'h0B000, 8'h33, 0);
        end_dl("rng");

        // Randomised downloads.
        for (int d = 0; d < 5; d++) begin
            start_dl();
            for (int i = 0; i < int'($urandom_range(5, 20)); i++) begin
                if ($urandom_range(0, 7) == 0) a = 25'h10000 + 25'($urandom_range(0, 16'hFFFF));
                else                           a = 25'($urandom_range(0, 16'hFFFF));
                ack_lat = int'($urandom_range(0, 3));
                wr_byte(a, 8'($urandom), d > 1 && $urandom_range(0, 9) == 0);
            end
            end_dl("rand");
        end

        // Async reset while a write is waiting for ack.
        start_dl();
        ack_lat = 5;
        wr_byte(25'h0A100, 8'h99, 0);
        @(negedge clk_sys);
        check("mid_we_pending", 32'(rom_we), 32'b0100);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_we_async",   32'(rom_we),     32'd0);
        check("mid_wait_async", 32'(ioctl_wait), 32'd0);
        check("mid_core_rst",   32'(core_reset), 32'd1);
        exp_q.delete();
        got_byte = 0;
        ioctl_download = 1'b0;
        ack_lat = 0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        measure_hold(h);
        check("mid_hold",      32'(h),         32'(HOLD));
        check("mid_load_done", 32'(load_done), 32'd0);

        repeat (4) @(negedge clk_sys);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
